// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V core. Classifies the instruction held in the
// EX/MEM register as a load, a store or a pass-through. Legal memory accesses
// run one request/response transaction on the data-memory port and stall the
// pipeline while it is outstanding. Results are captured into the MEM/WB
// register.
//
// Handshake: a request transfers on a rising clk edge where dmem_req_valid=1
// and dmem_req_ready=1. While valid is high and ready is low, every dmem_req_*
// field is held unchanged. A load's response is the single cycle in RESP with
// dmem_rsp_valid=1. dmem_rsp_valid is ignored in every other state.
//
// MEM/WB holds its last captured value while the stage is stalled.
module mem_access_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
  input  logic [6:0]                EX_MEM_inst_opcode,
  input  logic [2:0]                EX_MEM_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_reg_write_en,
  input  logic                      EX_MEM_mem_write_en,
  input  logic                      EX_MEM_wb_sel,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_req_we,
  output logic [31:0]               dmem_req_addr,
  output logic [31:0]               dmem_req_wdata,
  output logic [3:0]                dmem_req_be,
  input  logic                      dmem_rsp_valid,
  input  logic [31:0]               dmem_rsp_rdata,
  output logic                      mem_stall,
  output logic                      mem_exc,
  output logic [REG_WIDTH-1:0]      MEM_WB_alu_out,
  output logic [REG_WIDTH-1:0]      MEM_WB_load_data,
  output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  output logic                      MEM_WB_reg_write_en,
  output logic                      MEM_WB_wb_sel,
  output logic [1:0]                fsm_state
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [1:0]  a;
  logic        is_load, is_store, is_mem;
  logic        f3_ok, align_ok, legal_mem, bad_access;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        capture;

  // Request fields are frozen here when the access leaves IDLE.
  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_be_q;
  logic [2:0]  req_f3_q;
  logic [1:0]  req_a_q;
  logic [31:0] rsp_shifted;
  logic [31:0] rsp_extract;
  logic [31:0] load_data_q;

  // Classify the EX/MEM instruction and check funct3 and alignment.
  always_comb begin
    a          = EX_MEM_alu_out[1:0];
    is_load    = (EX_MEM_inst_opcode == OP_LOAD);
    is_store   = !is_load && EX_MEM_mem_write_en;
    is_mem     = is_load || is_store;
    f3_ok      = 1'b0;
    align_ok   = 1'b0;
    case (EX_MEM_funct3)
      3'b000:  f3_ok = 1'b1;
      3'b001:  f3_ok = 1'b1;
      3'b010:  f3_ok = 1'b1;
      3'b100:  f3_ok = is_load;
      3'b101:  f3_ok = is_load;
      default: f3_ok = 1'b0;
    endcase
    case (EX_MEM_funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = !a[0];
      2'b10:   align_ok = (a == 2'b00);
      default: align_ok = 1'b0;
    endcase
    legal_mem  = is_mem && f3_ok && align_ok;
    bad_access = is_mem && !(f3_ok && align_ok);
  end

  // Byte lanes and replicated store data. Loads read the full word.
  always_comb begin
    lane_be    = 4'hF;
    lane_wdata = 32'h0;
    if (is_store) begin
      case (EX_MEM_funct3[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << a;
          lane_wdata = {4{EX_MEM_dataB[7:0]}};
        end
        2'b01: begin
          lane_be    = 4'b0011 << a;
          lane_wdata = {2{EX_MEM_dataB[15:0]}};
        end
        default: begin
          lane_be    = 4'hF;
          lane_wdata = EX_MEM_dataB;
        end
      endcase
    end
  end

  // Align the returned word to the addressed byte and extend it to 32 bits.
  always_comb begin
    rsp_shifted = dmem_rsp_rdata >> {req_a_q, 3'b000};
    case (req_f3_q)
      3'b000:  rsp_extract = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  rsp_extract = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  rsp_extract = {24'h0, rsp_shifted[7:0]};
      3'b101:  rsp_extract = {16'h0, rsp_shifted[15:0]};
      default: rsp_extract = rsp_shifted;
    endcase
  end

  // Next-state logic for the access FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (legal_mem) state_nxt = S_REQ;
      S_REQ:   if (dmem_req_ready) state_nxt = req_we_q ? S_DONE : S_RESP;
      S_RESP:  if (dmem_rsp_valid) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Freeze the request fields when a legal access leaves IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_be_q    <= 4'h0;
      req_f3_q    <= 3'h0;
      req_a_q     <= 2'h0;
    end else if (state == S_IDLE && legal_mem) begin
      req_we_q    <= is_store;
      req_addr_q  <= {EX_MEM_alu_out[31:2], 2'b00};
      req_wdata_q <= lane_wdata;
      req_be_q    <= lane_be;
      req_f3_q    <= EX_MEM_funct3;
      req_a_q     <= a;
    end
  end

  // Latch the extracted load data when the response arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              load_data_q <= 32'h0;
    else if (state == S_RESP && dmem_rsp_valid) load_data_q <= rsp_extract;
  end

  // A bad access raises mem_exc for the single cycle after it is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_exc <= 1'b0;
    else          mem_exc <= (state == S_IDLE) && bad_access;
  end

  assign capture = ((state == S_IDLE) && !legal_mem) || (state == S_DONE);

  // MEM/WB register. A bad access retires like a pass-through with no write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MEM_WB_alu_out      <= '0;
      MEM_WB_load_data    <= '0;
      MEM_WB_rd           <= '0;
      MEM_WB_reg_write_en <= 1'b0;
      MEM_WB_wb_sel       <= 1'b0;
    end else if (capture) begin
      MEM_WB_alu_out      <= EX_MEM_alu_out;
      MEM_WB_rd           <= EX_MEM_rd;
      MEM_WB_wb_sel       <= EX_MEM_wb_sel;
      if (state == S_DONE) begin
        MEM_WB_reg_write_en <= EX_MEM_reg_write_en;
        MEM_WB_load_data    <= req_we_q ? 32'h0 : load_data_q;
      end else begin
        MEM_WB_reg_write_en <= EX_MEM_reg_write_en && !bad_access;
        MEM_WB_load_data    <= 32'h0;
      end
    end
  end

  // Port drive and pipeline stall.
  always_comb begin
    dmem_req_valid = (state == S_REQ);
    dmem_req_we    = req_we_q;
    dmem_req_addr  = req_addr_q;
    dmem_req_wdata = req_wdata_q;
    dmem_req_be    = req_be_q;
    mem_stall      = (state == S_REQ) || (state == S_RESP) ||
                     ((state == S_IDLE) && legal_mem);
    fsm_state      = state;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases followed by randomized
// loads, stores and pass-throughs, checked against a behavioural model.
module tb_mem_access_stage;

  localparam int W = 71;  // {alu_out, load_data, rd, reg_write_en, wb_sel}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] EX_MEM_alu_out = '0;
  logic [31:0] EX_MEM_dataB = '0;
  logic [6:0]  EX_MEM_inst_opcode = '0;
  logic [2:0]  EX_MEM_funct3 = '0;
  logic [4:0]  EX_MEM_rd = '0;
  logic        EX_MEM_reg_write_en = 1'b0;
  logic        EX_MEM_mem_write_en = 1'b0;
  logic        EX_MEM_wb_sel = 1'b0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        mem_stall;
  logic        mem_exc;
  logic [31:0] MEM_WB_alu_out;
  logic [31:0] MEM_WB_load_data;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_reg_write_en;
  logic        MEM_WB_wb_sel;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_wb = '0;

  mem_access_stage #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB),
    .EX_MEM_inst_opcode(EX_MEM_inst_opcode), .EX_MEM_funct3(EX_MEM_funct3),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write_en(EX_MEM_reg_write_en),
    .EX_MEM_mem_write_en(EX_MEM_mem_write_en), .EX_MEM_wb_sel(EX_MEM_wb_sel),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .mem_stall(mem_stall), .mem_exc(mem_exc),
    .MEM_WB_alu_out(MEM_WB_alu_out), .MEM_WB_load_data(MEM_WB_load_data),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write_en(MEM_WB_reg_write_en),
    .MEM_WB_wb_sel(MEM_WB_wb_sel), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wb_now();
    return {MEM_WB_alu_out, MEM_WB_load_data, MEM_WB_rd, MEM_WB_reg_write_en, MEM_WB_wb_sel};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit ref_legal(bit ld, bit st, int f3, logic [31:0] addr);
    int size;
    int lo;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
    if (st && f3 > 2) return 0;
    size = 1 << (f3 % 4);
    lo = int'(addr[1:0]);
    return (lo % size) == 0;
  endfunction

  function automatic logic [3:0] ref_be(bit st, int f3, int a);
    int v;
    if (!st) return 4'hF;
    if (f3 == 0)      v = 1 << a;
    else if (f3 == 1) v = 3 << a;
    else              v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(bit st, int f3, logic [31:0] d);
    if (!st) return 32'h0;
    if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(int f3, int a, logic [31:0] rdata);
    longint v;
    v = longint'({32'h0, rdata}) / (longint'(1) << (8 * a));
    if (f3 == 0 || f3 == 4)      v = v % 256;
    else if (f3 == 1 || f3 == 5) v = v % 65536;
    if (f3 == 0 && v >= 128)   v = v - 256;
    if (f3 == 1 && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after MEM/WB capture.
  task automatic run_op(input bit ld, input bit st, input int f3, input logic [31:0] addr,
                        input logic [31:0] data_b, input logic [4:0] rd, input bit rwe,
                        input bit wbsel, input logic [31:0] rdata, input int rdly, input int sdly);
    bit legal, bad;
    int a;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    logic [W-1:0] rec;
    a     = int'(addr[1:0]);
    bad   = (ld || st) && !ref_legal(ld, st, f3, addr);
    legal = (ld || st) && !bad;
    e_be  = ref_be(st, f3, a);
    e_wd  = ref_wdata(st, f3, data_b);
    e_ld  = (legal && ld) ? ref_load(f3, a, rdata) : 32'h0;
    exp_q.push_back({addr, e_ld, rd, rwe && !bad, wbsel});

    EX_MEM_inst_opcode  = ld ? 7'b0000011 : (st ? 7'b0100011 : 7'b0110011);
    EX_MEM_mem_write_en = st;
    EX_MEM_funct3       = f3[2:0];
    EX_MEM_alu_out      = addr;
    EX_MEM_dataB        = data_b;
    EX_MEM_rd           = rd;
    EX_MEM_reg_write_en = rwe;
    EX_MEM_wb_sel       = wbsel;
    dmem_req_ready      = 1'b0;
    dmem_rsp_valid      = 1'($urandom_range(0, 1));
    dmem_rsp_rdata      = $urandom();
    #1;
    check("idle_state", fsm_state, ST_IDLE);
    check("idle_stall", mem_stall, legal);
    check("idle_req_valid", dmem_req_valid, 0);
    check("idle_wb_hold", wb_now(), cur_wb);

    if (legal) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= rdly; i++) begin
        check("req_state", fsm_state, ST_REQ);
        check("req_valid", dmem_req_valid, 1);
        check("req_stall", mem_stall, 1);
        check("req_we", dmem_req_we, st);
        check("req_addr", dmem_req_addr, {addr[31:2], 2'b00});
        check("req_be", dmem_req_be, e_be);
        check("req_wdata", dmem_req_wdata, e_wd);
        check("req_exc", mem_exc, 0);
        check("req_wb_hold", wb_now(), cur_wb);
        dmem_req_ready = (i == rdly);
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rsp_rdata = $urandom();
        @(posedge clk); @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      if (ld) begin
        for (int i = 0; i <= sdly; i++) begin
          check("resp_state", fsm_state, ST_RESP);
          check("resp_stall", mem_stall, 1);
          check("resp_valid_low", dmem_req_valid, 0);
          dmem_rsp_valid = (i == sdly);
          dmem_rsp_rdata = (i == sdly) ? rdata : $urandom();
          @(posedge clk); @(negedge clk);
        end
      end
      dmem_rsp_valid = 1'b0;
      check("done_state", fsm_state, ST_DONE);
      check("done_stall", mem_stall, 0);
      check("done_req_valid", dmem_req_valid, 0);
      check("done_wb_hold", wb_now(), cur_wb);
    end
    @(posedge clk); @(negedge clk);
    dmem_rsp_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      rec = exp_q.pop_front();
      check("wb_alu_out", MEM_WB_alu_out, rec[70:39]);
      check("wb_load_data", MEM_WB_load_data, rec[38:7]);
      check("wb_rd_we_sel", {MEM_WB_rd, MEM_WB_reg_write_en, MEM_WB_wb_sel}, rec[6:0]);
      check("mem_exc", mem_exc, bad);
      cur_wb = rec;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    #3;
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_exc", mem_exc, 0);
    check("rst_wb", wb_now(), '0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // pass-through ADD
    run_op(0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0, 0, 0);
    // LB from 0x103, byte 0x80 sign-extends
    run_op(1, 0, 0, 32'h0000_0103, 32'h0, 5'd7, 1, 1, 32'h80AB_CDEF, 0, 0);
    // SH to 0x202 with ready held low for three cycles
    run_op(0, 1, 1, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 32'h0, 3, 0);
    // misaligned LW
    run_op(1, 0, 2, 32'h0000_0101, 32'h0, 5'd9, 1, 1, 32'h0, 0, 0);
    // illegal store funct3
    run_op(0, 1, 4, 32'h0000_0300, 32'h1234_5678, 5'd3, 0, 0, 32'h0, 0, 0);
    // back-to-back SW then LBU 0x3FF
    run_op(0, 1, 2, 32'h0000_0400, 32'h1122_3344, 5'd0, 0, 0, 32'h0, 1, 0);
    run_op(1, 0, 4, 32'h0000_03FF, 32'h0, 5'd12, 1, 1, 32'hF012_3456, 0, 2);

    // reset while in RESP, then a late response
    EX_MEM_inst_opcode  = 7'b0000011;
    EX_MEM_mem_write_en = 1'b0;
    EX_MEM_funct3       = 3'b010;
    EX_MEM_alu_out      = 32'h0000_0010;
    EX_MEM_rd           = 5'd4;
    EX_MEM_reg_write_en = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b0;
    check("pre_rst_state", fsm_state, ST_RESP);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_state", fsm_state, ST_IDLE);
    check("async_rst_valid", dmem_req_valid, 0);
    check("async_rst_wb", wb_now(), '0);
    check("async_rst_exc", mem_exc, 0);
    EX_MEM_inst_opcode  = 7'b0010011;
    EX_MEM_alu_out      = 32'h0;
    EX_MEM_rd           = 5'd0;
    EX_MEM_reg_write_en = 1'b0;
    EX_MEM_wb_sel       = 1'b0;
    @(negedge clk);
    reset_n        = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check("late_rsp_state", fsm_state, ST_IDLE);
    check("late_rsp_wb", wb_now(), '0);
    cur_wb = '0;

    // randomized mix
    for (int n = 0; n < 200; n++) begin
      int kind, f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) begin
        int sel;
        sel = $urandom_range(0, (kind == 1) ? 4 : 2);
        f3 = (sel >= 3) ? sel + 1 : sel;
      end else begin
        f3 = $urandom_range(0, 7);
      end
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_op(kind == 1, kind == 2, f3, addr, $urandom(), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
